// File: rtl/mux21_rr_arbiter_pkg.sv
// Shared definitions for the two-requester round-robin mux arbiter.
//   state_t           : arbiter FSM states (IDLE / grant to 0 / grant to 1)
//   DEFAULT_MAX_HOLD  : default fairness limit in consecutive contended cycles
package mux21_rr_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_t;

  localparam int unsigned DEFAULT_MAX_HOLD = 4;

endpackage

// File: rtl/mux21_rr_arbiter_mux2.sv
// Single-bit 2:1 mux cell.
//   i_a   : data selected when i_sel = 0
//   i_b   : data selected when i_sel = 1
//   i_sel : select
//   o_y   : selected data
module mux21_rr_arbiter_mux2 (
  input  logic i_a,
  input  logic i_b,
  input  logic i_sel,
  output logic o_y
);

  assign o_y = i_sel ? i_b : i_a;

endmodule

// File: rtl/mux21_rr_arbiter.sv
// Two-requester round-robin arbiter sharing one 2:1 datapath mux.
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   req[1:0]  : per-source request
//   in0, in1  : source data
//   gnt[1:0]  : one-hot grant, 00 = nobody
//   sel       : registered mux select (0 = in0, 1 = in1)
//   out       : registered muxed data
//   out_valid : out holds data from a granted, requesting source
// A holder that is contended for MAX_HOLD consecutive cycles is forced off
// the mux; an uncontended holder keeps it indefinitely.
module mux21_rr_arbiter
  import mux21_rr_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH    = 1,
  parameter int unsigned MAX_HOLD = DEFAULT_MAX_HOLD
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic [1:0]       gnt,
  output logic             sel,
  output logic [WIDTH-1:0] out,
  output logic             out_valid
);

  localparam int unsigned     HW       = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0]   HOLD_LIM = HW'(MAX_HOLD - 1);

  state_t            r_state, w_state_nxt;
  logic [HW-1:0]     r_hold, w_hold_nxt;
  logic              r_last, w_last_nxt;
  logic              r_sel, w_sel_nxt;
  logic [WIDTH-1:0]  r_out;
  logic              r_out_valid;
  logic [WIDTH-1:0]  w_mux;
  logic              w_own_req;

  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    w_last_nxt  = r_last;
    w_sel_nxt   = r_sel;

    unique case (r_state)
      IDLE: begin
        unique case (req)
          2'b01:   w_state_nxt = G0;
          2'b10:   w_state_nxt = G1;
          2'b11:   w_state_nxt = r_last ? G0 : G1;
          default: w_state_nxt = IDLE;
        endcase
      end
      G0: begin
        if (!req[0])                         w_state_nxt = req[1] ? G1 : IDLE;
        else if (req[1] && r_hold == HOLD_LIM) w_state_nxt = G1;
        else                                 w_hold_nxt = req[1] ? r_hold + 1'b1 : '0;
      end
      G1: begin
        if (!req[1])                         w_state_nxt = req[0] ? G0 : IDLE;
        else if (req[0] && r_hold == HOLD_LIM) w_state_nxt = G0;
        else                                 w_hold_nxt = req[0] ? r_hold + 1'b1 : '0;
      end
      default: w_state_nxt = IDLE;
    endcase

    // Entry into a grant state restarts the hold count and records the owner;
    // sel follows the owner and keeps its value through IDLE.
    if (w_state_nxt != r_state) begin
      if (w_state_nxt == G0) begin
        w_hold_nxt = '0;
        w_last_nxt = 1'b0;
        w_sel_nxt  = 1'b0;
      end else if (w_state_nxt == G1) begin
        w_hold_nxt = '0;
        w_last_nxt = 1'b1;
        w_sel_nxt  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_hold  <= '0;
      r_last  <= 1'b1;
      r_sel   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_hold  <= w_hold_nxt;
      r_last  <= w_last_nxt;
      r_sel   <= w_sel_nxt;
    end
  end

  for (genvar b = 0; b < WIDTH; b++) begin : g_mux
    mux21_rr_arbiter_mux2 u_mux (
      .i_a   (in0[b]),
      .i_b   (in1[b]),
      .i_sel (r_sel),
      .o_y   (w_mux[b])
    );
  end

  assign w_own_req = ((r_state == G0) && req[0]) || ((r_state == G1) && req[1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= w_own_req;
      if (w_own_req) r_out <= w_mux;
    end
  end

  assign gnt       = {r_state == G1, r_state == G0};
  assign sel       = r_sel;
  assign out       = r_out;
  assign out_valid = r_out_valid;

endmodule
